// File: rtl/svm_strobe_gen.sv
// svm_strobe_gen
// Capture/release strobe generator for the SVM datapath. Runs a valid/ready
// handshake with the feature-vector source and emits a capture strobe when a
// vector begins. It emits a release strobe PIPE_DEPTH cycles after that
// vector's last beat is accepted. In-flight vectors are counted, and new
// vectors are held off once MAX_INFLIGHT vectors are outstanding.
//
// Parameters:
//   PIPE_DEPTH   : cycles from last-beat accept to release strobe (>= 1)
//   MAX_INFLIGHT : credit limit on captured-but-unreleased vectors (>= 1)
//   CNT_W        : width of inflight (2**CNT_W > MAX_INFLIGHT)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   source presents a feature beat
//   in_last    in   beat is the final feature of its vector
//   in_ready   out  beat accepted this cycle (combinational from registers)
//   capture_l  out  one-cycle pulse: a new vector has begun
//   release_l  out  one-cycle pulse: a vector's result exits the pipeline
//   inflight   out  vectors captured and not yet released
//   vec_count  out  released vectors, wraps modulo 2**16

module svm_strobe_gen #(
  parameter int unsigned PIPE_DEPTH   = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             capture_l,
  output logic             release_l,
  output logic [CNT_W-1:0] inflight,
  output logic [15:0]      vec_count
);

  localparam int unsigned VC_W = 16;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [PIPE_DEPTH-1:0] dly;
  logic                  accept;
  logic                  vstart;
  logic                  vend;

  // Credits only gate the first beat; a vector already in progress is
  // never stalled mid-stream.
  assign in_ready = (state == BUSY) | (inflight < MAX_CNT);

  assign accept = in_valid & in_ready;
  assign vstart = accept & (state == IDLE);
  assign vend   = accept & in_last;

  // The final delay stage is itself the registered release strobe.
  assign release_l = dly[PIPE_DEPTH-1];

  // Vector framing FSM, strobe/delay line, and credit/completion counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dly       <= '0;
      capture_l <= 1'b0;
      inflight  <= '0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE:    if (accept && !in_last) state <= BUSY;
        BUSY:    if (accept && in_last)  state <= IDLE;
        default: state <= IDLE;
      endcase

      capture_l <= vstart;

      // One bit per cycle of latency; several vectors may be in the line.
      dly <= (dly << 1) | PIPE_DEPTH'(vend);

      // Coincident capture and release leave the count unchanged.
      case ({vstart, release_l})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      if (release_l) vec_count <= vec_count + VC_W'(1);
    end
  end

endmodule

// File: tb/tb_svm_strobe_gen.sv
module tb_svm_strobe_gen;

  localparam int unsigned PD   = 8;
  localparam int unsigned MAXI = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned OW   = 3 + CW + 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          capture_l;
  logic          release_l;
  logic [CW-1:0] inflight;
  logic [15:0]   vec_count;

  svm_strobe_gen #(.PIPE_DEPTH(PD), .MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .capture_l(capture_l), .release_l(release_l),
    .inflight(inflight), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: vectors tracked by scheduled release cycle numbers.
  int      cyc = 0;
  bit      m_in_vec;
  int      m_inf;
  int      m_vc;
  bit      m_cap;
  int      rel_q[$];
  bit      exp_rdy;
  bit      exp_rel;
  logic [OW-1:0] exp_w;
  logic [OW-1:0] obs_w;

  assign obs_w = {in_ready, capture_l, release_l, inflight, vec_count};

  task automatic model_reset();
    rel_q.delete();
    m_in_vec = 1'b0;
    m_inf    = 0;
    m_vc     = 0;
    m_cap    = 1'b0;
  endtask

  task automatic model_expect();
    exp_rdy = m_in_vec || (m_inf < int'(MAXI));
    exp_rel = (rel_q.size() != 0) && (rel_q[0] == cyc);
    exp_w   = {exp_rdy, m_cap, exp_rel, CW'(m_inf), 16'(m_vc)};
  endtask

  // Drive one cycle's inputs away from the active edge and form expectations.
  task automatic drive(input bit v, input bit l);
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    #1;
    model_expect();
  endtask

  // Apply the accept decision of the current cycle, then wait out the edge.
  task automatic advance();
    bit acc, vs;
    acc = in_valid && exp_rdy;
    vs  = acc && !m_in_vec;
    if (acc) begin
      if (in_last) begin
        rel_q.push_back(cyc + int'(PD));
        m_in_vec = 1'b0;
      end else begin
        m_in_vec = 1'b1;
      end
    end
    if (exp_rel) begin
      void'(rel_q.pop_front());
      m_vc = (m_vc + 1) % 65536;
    end
    m_inf = m_inf + int'(vs) - int'(exp_rel);
    m_cap = vs;
    cyc++;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_vec++;
      if (obs_w !== {1'b1, 26'd0}) begin
        n_err++;
        $display("FAIL reset k=%0d: got %h want %h", k, obs_w, {1'b1, 26'd0});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL reset_after k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      advance();
    end
  endtask

  task automatic test_three_beat();
    int vc0;
    vc0 = m_vc;
    for (int k = 0; k < 15; k++) begin
      drive(k <= 2, k == 2);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL three_beat model k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      n_vec++;
      if (capture_l !== (k == 1) || release_l !== (k == 10) ||
          inflight !== CW'((k >= 1 && k <= 10) ? 1 : 0)) begin
        n_err++;
        $display("FAIL three_beat strobes k=%0d: got cap=%b rel=%b inf=%0d", k,
                 capture_l, release_l, inflight);
      end
      advance();
    end
    n_vec++;
    if (vec_count !== 16'(vc0 + 1)) begin
      n_err++;
      $display("FAIL three_beat vec_count: got %0d want %0d", vec_count, vc0 + 1);
    end
  endtask

  task automatic test_single_beat();
    for (int k = 0; k < 11; k++) begin
      drive(k == 0, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL single_beat model k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      n_vec++;
      if (capture_l !== (k == 1) || release_l !== (k == 8) ||
          inflight !== CW'((k >= 1 && k <= 8) ? 1 : 0)) begin
        n_err++;
        $display("FAIL single_beat strobes k=%0d: got cap=%b rel=%b inf=%0d", k,
                 capture_l, release_l, inflight);
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    int vc0;
    vc0 = m_vc;
    for (int k = 0; k < 20; k++) begin
      drive(k <= 9, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL back_pressure model k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      n_vec++;
      if (release_l !== (k == 8 || k == 9 || k == 10 || k == 11 || k == 17) ||
          (k <= 9 && in_ready !== !(k >= 4 && k <= 8)) ||
          (k == 9 && inflight !== CW'(3))) begin
        n_err++;
        $display("FAIL back_pressure k=%0d: got rdy=%b rel=%b inf=%0d", k,
                 in_ready, release_l, inflight);
      end
      advance();
    end
    n_vec++;
    if (vec_count !== 16'(vc0 + 5)) begin
      n_err++;
      $display("FAIL back_pressure vec_count: got %0d want %0d", vec_count, vc0 + 5);
    end
  endtask

  // A at 0 (release 8); B starts at 7 so its capture meets A's release;
  // C starts at 15, the very cycle B releases.
  task automatic test_coincident();
    for (int k = 0; k < 26; k++) begin
      drive(k == 0 || k == 7 || k == 15, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL coincident model k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      if (k == 8) begin
        n_vec++;
        if (capture_l !== 1'b1 || release_l !== 1'b1 || inflight !== CW'(2)) begin
          n_err++;
          $display("FAIL coincident both k=8: got cap=%b rel=%b inf=%0d want 1 1 2",
                   capture_l, release_l, inflight);
        end
      end
      if (k == 15 || k == 16) begin
        n_vec++;
        if (inflight !== CW'(1) || release_l !== (k == 15)) begin
          n_err++;
          $display("FAIL coincident hold k=%0d: got inf=%0d rel=%b want 1 %b", k,
                   inflight, release_l, k == 15);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL random k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      advance();
    end
    for (int k = 0; k < int'(2 * PD) + 2; k++) begin
      drive(k == 0, 1'b1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL random_drain k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k <= 2, k != 1);
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL midflight pre k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      advance();
    end
    n_vec++;
    if (inflight !== CW'(2)) begin
      n_err++;
      $display("FAIL midflight pending: got inf=%0d want 2", inflight);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (obs_w !== {1'b1, 26'd0}) begin
      n_err++;
      $display("FAIL midflight async: got %h want %h", obs_w, {1'b1, 26'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < int'(2 * PD); k++) begin
      drive(1'b0, 1'b0);
      n_vec++;
      if (obs_w !== exp_w || release_l !== 1'b0 || vec_count !== 16'd0) begin
        n_err++;
        $display("FAIL midflight post k=%0d: got %h want %h", k, obs_w, exp_w);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    test_reset();
    test_three_beat();
    test_single_beat();
    test_back_pressure();
    test_coincident();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
